eth_txbackoff: RTL

- Collision-retry and backoff scheduler for the MAC transmit path.
- Tracks collision count per frame and draws a truncated-binary-exponential random slot count from an LFSR.
- Times backoff slots in nibbles and tracks the collision window.
- Drives the tx state machine's RandomEq0, RandomEqByteCnt, RetryMax and ColWindow inputs; sits beside it in the tx top level, clocked by MTxClk.

---
 rtl/eth_txbackoff_pkg.sv | 24 ++
 rtl/eth_txbackoff_lfsr.sv | 45 ++++
 rtl/eth_txbackoff.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/eth_txbackoff_pkg.sv
// eth_txbackoff_pkg
// Constants shared by the transmit backoff scheduler and its LFSR:
// LFSR width, feedback taps and default seed, the truncation limit of
// the exponential backoff range, the slot length in nibbles and the
// retry counter width.
package eth_txbackoff_pkg;

  localparam int LFSR_W      = 10;
  // Feedback polynomial x^10 + x^3 + 1 as zero-based bit positions.
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 2;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 10'h3FF;

  localparam int BACKOFF_LIMIT_DEFAULT = 10;
  localparam int SLOT_NIBBLES_DEFAULT  = 128;

  localparam int RETRY_W = 4;
  // Width wide enough to hold an exponent k in 0..RETRY_W-bit max + 1.
  localparam int EXP_W   = 5;
  localparam int NIB_W   = 7;
  localparam int COL_W   = 7;

endpackage

// File: rtl/eth_txbackoff_lfsr.sv
// eth_txbackoff_lfsr
// Free-running 10-bit Fibonacci LFSR (x^10 + x^3 + 1) that supplies the
// random bits for the backoff draw, plus the mask that keeps the low k
// bits of a draw.
// Ports:
//   MTxClk  - transmit nibble clock
//   Reset   - asynchronous, active-high; loads SEED
//   exp_i   - exponent k (number of low bits to keep)
//   lfsr_o  - current LFSR state
//   mask_o  - (2^k)-1, saturated to all ones for k >= LFSR_W
module eth_txbackoff_lfsr
  import eth_txbackoff_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic              MTxClk,
  input  logic              Reset,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [LFSR_W-1:0] lfsr_o,
  output logic [LFSR_W-1:0] mask_o
);

  function automatic logic [LFSR_W-1:0] exp_mask(input logic [EXP_W-1:0] k);
    logic [LFSR_W-1:0] m;
    m = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      if (i < int'(k)) m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
  assign mask_o = exp_mask(exp_i);

endmodule

// File: rtl/eth_txbackoff.sv
// eth_txbackoff
// Collision-retry and truncated binary exponential backoff scheduler for
// the MAC transmit path. Counts collisions per frame, draws a random slot
// count on the first jam cycle, times the backoff in nibbles and tracks
// the collision window.
// Optional build macro: ETH_TX_BACKOFF_FORCE_EN adds ForceRandom/ForceValue
// so the draw can be replaced by a fixed value.
// Ports:
//   MTxClk, Reset            - nibble clock, asynchronous active-high reset
//   StateIdle..StateBackOff  - tx FSM state decodes
//   TxDone, TxAbort          - end-of-frame pulses; clear retry state
//   MaxRet                   - retry limit
//   CollValid                - collision window length in bytes
//   RetryCnt, RetryMax       - collisions on this frame, limit reached
//   RandomEq0                - latched random backoff value is zero
//   RandomEqByteCnt          - one-cycle pulse when the backoff has elapsed
//   ColWindow                - still inside the collision window
module eth_txbackoff
  import eth_txbackoff_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_SEED_DEFAULT,
  parameter int                SLOT_NIBBLES  = SLOT_NIBBLES_DEFAULT,
  parameter int                BACKOFF_LIMIT = BACKOFF_LIMIT_DEFAULT
) (
  input  logic               MTxClk,
  input  logic               Reset,
  input  logic               StateIdle,
  input  logic               StatePreamble,
  input  logic [1:0]         StateData,
  input  logic               StateJam,
  input  logic               StateBackOff,
  input  logic               TxDone,
  input  logic               TxAbort,
  input  logic [RETRY_W-1:0] MaxRet,
  input  logic [5:0]         CollValid,
`ifdef ETH_TX_BACKOFF_FORCE_EN
  input  logic               ForceRandom,
  input  logic [LFSR_W-1:0]  ForceValue,
`endif
  output logic [RETRY_W-1:0] RetryCnt,
  output logic               RetryMax,
  output logic               RandomEq0,
  output logic               RandomEqByteCnt,
  output logic               ColWindow
);

  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(SLOT_NIBBLES - 1);
  localparam logic [EXP_W-1:0] EXP_MAX  = EXP_W'(BACKOFF_LIMIT);

  logic               jam_q;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LFSR_W-1:0]  rand_q, rand_d;
  logic               rand_eq0_q;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic [LFSR_W-1:0]  slot_q, slot_d;
  logic [COL_W-1:0]   col_q, col_d;

  logic               jam_first;
  logic               clear;
  logic [EXP_W-1:0]   rand_exp;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  rand_mask;
  logic [LFSR_W-1:0]  draw_src;

  eth_txbackoff_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .MTxClk (MTxClk),
    .Reset  (Reset),
    .exp_i  (rand_exp),
    .lfsr_o (lfsr),
    .mask_o (rand_mask)
  );

`ifdef ETH_TX_BACKOFF_FORCE_EN
  assign draw_src = ForceRandom ? ForceValue : lfsr;
`else
  assign draw_src = lfsr;
`endif

  assign jam_first = StateJam & ~jam_q;
  assign clear     = TxDone | TxAbort;

  // Exponent for this draw: the collision being counted now, capped.
  always_comb begin
    rand_exp = {1'b0, retry_q} + EXP_W'(1);
    if (rand_exp > EXP_MAX) rand_exp = EXP_MAX;
  end

  // End of frame wins over a coincident first jam cycle.
  always_comb begin
    retry_d = retry_q;
    rand_d  = rand_q;
    if (clear) begin
      retry_d = '0;
      rand_d  = '0;
    end else if (jam_first) begin
      if (retry_q != '1) retry_d = retry_q + RETRY_W'(1);
      rand_d = draw_src & rand_mask;
    end
  end

  // Slot timer runs only in backoff and restarts from zero on every entry.
  always_comb begin
    nib_d  = '0;
    slot_d = '0;
    if (StateBackOff) begin
      if (nib_q == NIB_LAST) begin
        nib_d  = '0;
        slot_d = slot_q + LFSR_W'(1);
      end else begin
        nib_d  = nib_q + NIB_W'(1);
        slot_d = slot_q;
      end
    end
  end

  always_comb begin
    col_d = col_q;
    if (StateIdle) begin
      col_d = '0;
    end else if ((StatePreamble || (StateData != 2'b00)) && (col_q != '1)) begin
      col_d = col_q + COL_W'(1);
    end
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      jam_q      <= 1'b0;
      retry_q    <= '0;
      rand_q     <= '0;
      rand_eq0_q <= 1'b1;
      nib_q      <= '0;
      slot_q     <= '0;
      col_q      <= '0;
    end else begin
      jam_q      <= StateJam;
      retry_q    <= retry_d;
      rand_q     <= rand_d;
      rand_eq0_q <= (rand_q == '0);
      nib_q      <= nib_d;
      slot_q     <= slot_d;
      col_q      <= col_d;
    end
  end

  assign RetryCnt  = retry_q;
  assign RetryMax  = (retry_q >= MaxRet);
  assign RandomEq0 = rand_eq0_q;
  // Compare in one extra bit so slot_q + 1 can never alias a small RandReg.
  assign RandomEqByteCnt = StateBackOff && (nib_q == NIB_LAST) &&
                           (({1'b0, slot_q} + 11'd1) == {1'b0, rand_q});
  // Window is measured in bytes, i.e. pairs of nibbles.
  assign ColWindow = (col_q[COL_W-1:1] < CollValid);

endmodule
